// File: rtl/nibble_serializer.sv
// nibble_serializer
// Accepts bytes on a valid/ready input port, buffers them in a small byte
// FIFO, and emits each byte as two 4-bit nibbles on a valid/ready output port.
// The output stage is a registered byte plus a three-state FSM (IDLE, FIRST,
// SECOND). Back-to-back bytes stream without bubbles when READY_IN stays high.
//
// Parameters:
//   DEPTH      byte FIFO entries (power of two, >= 2)
//   MSN_FIRST  1: nibble [7:4] goes out first, 0: nibble [3:0] goes out first
//   CNT_W      width of FIFO_COUNT, log2(DEPTH)+1
//
// Ports:
//   CLK         clock, all state updates on posedge
//   RESET       synchronous active-high reset
//   DATA_IN     byte from upstream
//   VALID_IN    DATA_IN valid
//   READY_OUT   a byte can be accepted this cycle
//   DATA_OUT    nibble to downstream (0 while VALID_OUT=0)
//   VALID_OUT   DATA_OUT valid
//   READY_IN    downstream accepts a nibble this cycle
//   FIFO_COUNT  bytes held in the FIFO, output stage excluded
module nibble_serializer #(
    parameter int DEPTH     = 4,
    parameter int MSN_FIRST = 1,
    parameter int CNT_W     = 3
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [7:0]       DATA_IN,
    input  logic             VALID_IN,
    output logic             READY_OUT,
    output logic [3:0]       DATA_OUT,
    output logic             VALID_OUT,
    input  logic             READY_IN,
    output logic [CNT_W-1:0] FIFO_COUNT
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [7:0]       mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] count;
    logic [7:0]       byte_p0;
    logic             push;
    logic             pop;
    logic             fifo_empty;

    function automatic logic [3:0] first_nibble(input logic [7:0] b);
        return (MSN_FIRST != 0) ? b[7:4] : b[3:0];
    endfunction

    function automatic logic [3:0] second_nibble(input logic [7:0] b);
        return (MSN_FIRST != 0) ? b[3:0] : b[7:4];
    endfunction

    assign fifo_empty = (count == '0);
    assign READY_OUT  = !RESET && (count < FULL);
    assign push       = VALID_IN && READY_OUT;
    assign FIFO_COUNT = count;

    // Output stage: VALID_OUT is implied by FIRST/SECOND, so a transfer in
    // those states reduces to READY_IN alone.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        VALID_OUT  = 1'b0;
        DATA_OUT   = 4'h0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = FIRST;
                end
            end
            FIRST: begin
                VALID_OUT = 1'b1;
                DATA_OUT  = first_nibble(byte_p0);
                if (READY_IN) begin
                    state_next = SECOND;
                end
            end
            SECOND: begin
                VALID_OUT = 1'b1;
                DATA_OUT  = second_nibble(byte_p0);
                if (READY_IN) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = FIRST;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Control state: FSM, pointers and occupancy.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            state <= state_next;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Byte storage and the output-stage byte register carry no reset; the
    // control state above decides whether their contents are meaningful.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= DATA_IN;
        end
        if (pop) begin
            byte_p0 <= mem[rd_ptr];
        end
    end

endmodule

// File: tb/tb_nibble_serializer.sv
module tb_nibble_serializer;

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic       vin;
    logic       rin;
    logic       rdy_m, rdy_l;
    logic [3:0] dout_m, dout_l;
    logic       vout_m, vout_l;
    logic [2:0] cnt_m, cnt_l;

    int checks = 0;
    int passes = 0;

    logic [3:0] q_m[$];
    logic [3:0] q_l[$];
    bit         hold_m = 1'b0, hold_l = 1'b0;
    logic [3:0] hdat_m = 4'h0, hdat_l = 4'h0;

    nibble_serializer #(.DEPTH(4), .MSN_FIRST(1), .CNT_W(3)) dut_m (
        .CLK(clk), .RESET(rst), .DATA_IN(din), .VALID_IN(vin), .READY_OUT(rdy_m),
        .DATA_OUT(dout_m), .VALID_OUT(vout_m), .READY_IN(rin), .FIFO_COUNT(cnt_m)
    );

    nibble_serializer #(.DEPTH(4), .MSN_FIRST(0), .CNT_W(3)) dut_l (
        .CLK(clk), .RESET(rst), .DATA_IN(din), .VALID_IN(vin), .READY_OUT(rdy_l),
        .DATA_OUT(dout_l), .VALID_OUT(vout_l), .READY_IN(rin), .FIFO_COUNT(cnt_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h, required %0h", name, got, exp);
    endtask

    // Monitor for one instance: handshakes are evaluated at negedge, where
    // inputs and outputs are stable for the coming posedge.
    task automatic mon(input bit msn, input logic v, input logic [3:0] d,
                       input logic rdy, inout bit hold, inout logic [3:0] hdat);
        logic [3:0] e;
        if (hold) begin
            check(msn ? "hold_valid_m" : "hold_valid_l", 32'(v), 32'd1);
            check(msn ? "hold_data_m" : "hold_data_l", 32'(d), 32'(hdat));
        end
        if (!v) check(msn ? "idle_zero_m" : "idle_zero_l", 32'(d), 32'd0);
        if (v && rin) begin
            if (msn) begin
                check("nibble_expected_m", 32'(q_m.size() != 0), 32'd1);
                if (q_m.size() != 0) begin
                    e = q_m.pop_front();
                    check("nibble_m", 32'(d), 32'(e));
                end
            end else begin
                check("nibble_expected_l", 32'(q_l.size() != 0), 32'd1);
                if (q_l.size() != 0) begin
                    e = q_l.pop_front();
                    check("nibble_l", 32'(d), 32'(e));
                end
            end
        end
        hold = v && !rin;
        hdat = d;
        if (vin && rdy) begin
            if (msn) begin
                q_m.push_back(din[7:4]);
                q_m.push_back(din[3:0]);
            end else begin
                q_l.push_back(din[3:0]);
                q_l.push_back(din[7:4]);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            q_m.delete();
            q_l.delete();
            hold_m = 1'b0;
            hold_l = 1'b0;
        end else begin
            mon(1'b1, vout_m, dout_m, rdy_m, hold_m, hdat_m);
            mon(1'b0, vout_l, dout_l, rdy_l, hold_l, hdat_l);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one byte until accepted (bounded); optionally check occupancy each cycle.
    task automatic push_byte(input logic [7:0] b, input bit chk34);
        bit ok;
        int guard;
        din   = b;
        vin   = 1'b1;
        guard = 0;
        do begin
            ok = rdy_m;
            step();
            if (chk34) check("cnt_3_or_4", 32'(cnt_m == 3'd3 || cnt_m == 3'd4), 32'd1);
            guard++;
        end while (!ok && guard < 20);
        check("push_accepted", 32'(ok), 32'd1);
    endtask

    task automatic drain();
        int guard;
        vin   = 1'b0;
        rin   = 1'b1;
        guard = 0;
        while ((vout_m || vout_l || cnt_m != 0) && guard < 40) begin
            step();
            guard++;
        end
        step();
        check("drain_idle", 32'(vout_m), 32'd0);
        check("drain_q_m", 32'(q_m.size()), 32'd0);
        check("drain_q_l", 32'(q_l.size()), 32'd0);
    endtask

    logic [7:0] bytes6 [6];

    initial begin
        rst = 1'b1; vin = 1'b0; rin = 1'b0; din = 8'h00;
        step();
        step();
        check("ready_in_reset", 32'(rdy_m), 32'd0);
        check("reset_valid", 32'(vout_m), 32'd0);
        check("reset_data", 32'(dout_m), 32'd0);
        check("reset_count", 32'(cnt_m), 32'd0);
        rst = 1'b0;
        #1;
        check("ready_after_reset", 32'(rdy_m), 32'd1);

        // Single byte 0xA5
        rin = 1'b1; din = 8'hA5; vin = 1'b1;
        step();
        vin = 1'b0;
        check("a5_not_yet_valid", 32'(vout_m), 32'd0);
        check("a5_count1", 32'(cnt_m), 32'd1);
        step();
        check("a5_valid", 32'(vout_m), 32'd1);
        check("a5_first_m", 32'(dout_m), 32'hA);
        check("a5_first_l", 32'(dout_l), 32'h5);
        step();
        check("a5_second_m", 32'(dout_m), 32'h5);
        step();
        check("a5_done_valid", 32'(vout_m), 32'd0);
        check("a5_done_count", 32'(cnt_m), 32'd0);

        // Back-to-back bytes, no output gaps
        for (int k = 0; k < 4; k++) begin
            din = 8'h12 + 8'(k * 8'h22);
            vin = 1'b1;
            check("b2b_ready", 32'(rdy_m), 32'd1);
            step();
        end
        vin = 1'b0;
        for (int k = 0; k < 6; k++) begin
            check("b2b_no_gap", 32'(vout_m), 32'd1);
            step();
        end
        check("b2b_end_valid", 32'(vout_m), 32'd0);
        check("b2b_end_count", 32'(cnt_m), 32'd0);

        // Stall downstream while pushing, then stream through a full FIFO
        rin = 1'b0;
        for (int k = 0; k < 6; k++) bytes6[k] = 8'($urandom);
        for (int k = 0; k < 5; k++) push_byte(bytes6[k], 1'b0);
        din = bytes6[5];
        vin = 1'b1;
        check("full_count", 32'(cnt_m), 32'd4);
        check("full_ready", 32'(rdy_m), 32'd0);
        check("stall_valid", 32'(vout_m), 32'd1);
        check("stall_first_nibble", 32'(dout_m), 32'(bytes6[0][7:4]));
        for (int k = 0; k < 3; k++) begin
            step();
            check("stall_count", 32'(cnt_m), 32'd4);
        end
        rin = 1'b1;
        push_byte(bytes6[5], 1'b1);
        for (int k = 0; k < 10; k++) push_byte(8'($urandom), 1'b1);
        drain();

        // Reset while in SECOND with three bytes queued
        rin = 1'b0;
        for (int k = 0; k < 4; k++) push_byte(8'($urandom), 1'b0);
        vin = 1'b0;
        rin = 1'b1;
        step();
        check("pre_reset_count", 32'(cnt_m), 32'd3);
        check("pre_reset_valid", 32'(vout_m), 32'd1);
        rin = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_reset_valid", 32'(vout_m), 32'd0);
        check("mid_reset_data", 32'(dout_m), 32'd0);
        check("mid_reset_count_m", 32'(cnt_m), 32'd0);
        check("mid_reset_count_l", 32'(cnt_l), 32'd0);
        #1;
        check("mid_reset_ready", 32'(rdy_m), 32'd1);
        rin = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            check("no_stale_nibble", 32'(vout_m | vout_l), 32'd0);
        end

        // LSN-first instance on 0xC3
        din = 8'hC3; vin = 1'b1;
        step();
        vin = 1'b0;
        step();
        check("c3_first_l", 32'(dout_l), 32'h3);
        check("c3_first_m", 32'(dout_m), 32'hC);
        step();
        check("c3_second_l", 32'(dout_l), 32'hC);
        step();

        // Randomized traffic checked by the scoreboard
        for (int k = 0; k < 400; k++) begin
            vin = 1'($urandom_range(0, 1));
            din = 8'($urandom);
            rin = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
